dec_scan_nto2n: RTL

Registered, parametrised N-to-2^N decoder with enable, selectable active polarity and an auto-scan mode that steps the active output through all lines at a programmable rate. It generalises the team's 2-to-4 decoder into a synchronous block for digit/row strobing of LED and 7-segment displays and for round-robin select generation. Outputs are registered and glitch-free, so they can drive pins directly.

---
 rtl/dec_pkg.sv | 23 ++
 rtl/dec_onehot.sv | 17 +
 rtl/dec_scan_nto2n.sv | 118 +++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
package dec_pkg;

    typedef enum logic [1:0] {
        ModeHold,
        ModeDirect,
        ModeEntry,
        ModeRun
    } mode_e;

    function automatic int unsigned out_width(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

    function automatic logic act_level(input bit active_low);
        return ~active_low;
    endfunction

    function automatic logic inact_level(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder.
module dec_onehot
    import dec_pkg::*;
#(
    parameter  int unsigned SEL_W = 2,
    localparam int unsigned OUT_W = out_width(SEL_W)
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/dec_scan_nto2n.sv
// Registered N-to-2^N decoder with enable, selectable polarity and a
// prescaled auto-scan mode for display strobing and round-robin selects.
module dec_scan_nto2n
    import dec_pkg::*;
#(
    parameter  int unsigned SEL_W      = 2,
    parameter  int unsigned DIV_W      = 16,
    parameter  bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned OUT_W      = out_width(SEL_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             scan,
    input  logic [SEL_W-1:0] sel,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_W-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             tick,
    output logic             wrap
);

    localparam logic [OUT_W-1:0] YInact = {OUT_W{inact_level(ACTIVE_LOW)}};

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             scan_q, scan_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic [OUT_W-1:0] onehot;
    logic             step_due;
    mode_e            mode;

    always_comb begin
        if (!en) begin
            mode = ModeHold;
        end else if (!scan) begin
            mode = ModeDirect;
        end else if (!scan_q) begin
            mode = ModeEntry;
        end else begin
            mode = ModeRun;
        end
    end

    // >= rather than == so lowering div mid-step advances at once instead of
    // letting the prescaler run all the way around.
    assign step_due = (pre_q >= div);

    always_comb begin
        idx_d  = idx_q;
        pre_d  = pre_q;
        scan_d = scan_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        unique case (mode)
            ModeHold: begin
            end
            ModeDirect: begin
                scan_d = 1'b0;
                idx_d  = sel;
                pre_d  = '0;
            end
            ModeEntry: begin
                scan_d = 1'b1;
                idx_d  = sel;
                pre_d  = '0;
            end
            ModeRun: begin
                if (step_due) begin
                    pre_d  = '0;
                    idx_d  = idx_q + SEL_W'(1);
                    tick_d = 1'b1;
                    wrap_d = &idx_q;
                end else begin
                    pre_d = pre_q + DIV_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    dec_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel    (idx_d),
        .onehot (onehot)
    );

    // XOR with the inactive level inverts the one-hot word for active-low use.
    assign y_d = en ? (onehot ^ YInact) : YInact;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            pre_q  <= '0;
            scan_q <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            y_q    <= YInact;
        end else begin
            idx_q  <= idx_d;
            pre_q  <= pre_d;
            scan_q <= scan_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            y_q    <= y_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule
